// File: rtl/arb_mux_param_pkg.sv
// Shared constants and helpers for the arbitrating mux.
// Arbitration mode encodings and index-width function.
package arb_mux_param_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Index width that never collapses to zero for a single channel.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_param_rr_arbiter.sv
// Combinational request arbiter, round-robin or fixed priority.
// Reusable by any block sharing one resource among N requesters.
module rr_arbiter
    import arb_mux_param_pkg::*;
#(
    parameter int N    = 2,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last_grant,
    input  logic            mode,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    int  idx;
    logic found;

    // Pick the first requester after last_grant, or the lowest index in fixed mode.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) grant = SELW'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(last_grant) + 1 + i) % N;
                if (!found && req[idx]) begin
                    grant = SELW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign grant_vld = |req;

endmodule

// File: rtl/arb_mux_param.sv
// N-channel arbitrating mux with a registered, backpressure-safe output.
// out_ready reaches in_ready combinationally; data paths are registered.
module arb_mux_param
    import arb_mux_param_pkg::*;
#(
    parameter int N        = 2,
    parameter int WIDTH    = 32,
    parameter int ARB_MODE = ARB_RR,
    parameter int SELW     = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic [SELW-1:0] last_grant;
    logic [SELW-1:0] grant;
    logic            grant_vld;
    logic            load_en;

    assign load_en = !out_valid || out_ready;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .mode       (ARB_MODE == ARB_FIXED),
        .grant      (grant),
        .grant_vld  (grant_vld)
    );

    // One-hot accept for the granted channel, suppressed during reset.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = !reset && load_en && grant_vld
                          && (int'(grant) == k);
        end
    end

    // Output slice: load on free/accepted slot, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SELW'(N - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid  <= 1'b1;
                out_data   <= in_data[int'(grant)*WIDTH +: WIDTH];
                out_sel    <= grant;
                last_grant <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_param.sv
// Bench for arb_mux_param: round-robin and fixed-priority instances
// driven by shared stimulus and compared with a behavioural model.
module tb_arb_mux_param;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   rdy [2];
    logic           ov  [2];
    logic [W-1:0]   od  [2];
    logic [SW-1:0]  os  [2];

    int errors = 0;
    int checks = 0;

    string names [2] = '{"rr", "fx"};

    bit       m_v    [2];
    logic [W-1:0] m_d [2];
    int       m_s    [2];
    int       m_last [2];

    always #5 clk = ~clk;

    arb_mux_param #(.N(N), .WIDTH(W), .ARB_MODE(0)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy[0]),
        .out_valid (ov[0]),
        .out_data  (od[0]),
        .out_sel   (os[0]),
        .out_ready (out_ready)
    );

    arb_mux_param #(.N(N), .WIDTH(W), .ARB_MODE(1)) u_fx (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy[1]),
        .out_valid (ov[1]),
        .out_data  (od[1]),
        .out_sel   (os[1]),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Who should win: fixed = lowest valid; rr = first after last grant.
    function automatic int mgrant(int d, logic [N-1:0] v);
        if (v == '0) return -1;
        if (d == 1) begin
            for (int k = 0; k < N; k++) if (v[k]) return k;
        end else begin
            for (int off = 1; off <= N; off++) begin
                int k;
                k = (m_last[d] + off) % N;
                if (v[k]) return k;
            end
        end
        return -1;
    endfunction

    task automatic cycle(input bit rst, input logic [N-1:0] v,
                         input logic [N*W-1:0] dat, input bit ordy);
        int g [2];
        bit le [2];
        logic [N-1:0] exp;
        @(negedge clk);
        reset = rst;
        in_valid = v;
        in_data = dat;
        out_ready = ordy;
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]  = mgrant(d, v);
            le[d] = !m_v[d] || ordy;
            exp = '0;
            if (!rst && le[d] && g[d] >= 0) exp[g[d]] = 1'b1;
            check({names[d], ".in_ready"}, 64'(rdy[d]), 64'(exp));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_v[d] = 1'b0;
                m_d[d] = '0;
                m_s[d] = 0;
                m_last[d] = N - 1;
            end else if (le[d]) begin
                if (g[d] >= 0) begin
                    m_v[d] = 1'b1;
                    m_d[d] = dat[g[d]*W +: W];
                    m_s[d] = g[d];
                    m_last[d] = g[d];
                end else begin
                    m_v[d] = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check({names[d], ".out_valid"}, 64'(ov[d]), 64'(m_v[d]));
            check({names[d], ".out_data"}, 64'(od[d]), 64'(m_d[d]));
            check({names[d], ".out_sel"}, 64'(os[d]), 64'(m_s[d]));
        end
    endtask

    function automatic logic [N*W-1:0] seq_data();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = 32'h1000 + k;
        return r;
    endfunction

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] dat;
        logic [N*W-1:0] sq;
        reset = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 1'b0;
            m_d[d] = '0;
            m_s[d] = 0;
            m_last[d] = N - 1;
        end
        sq = seq_data();

        // reset then idle
        cycle(1, 4'b0000, '0, 1);
        cycle(1, 4'b0000, '0, 1);
        cycle(0, 4'b0000, '0, 1);
        check("idle.out_valid", 64'(ov[0]), 64'd0);
        check("idle.out_sel", 64'(os[0]), 64'd0);

        // single request on channel 2
        dat = '0;
        dat[2*W +: W] = 32'hDEADBEEF;
        cycle(0, 4'b0100, dat, 1);
        check("single.out_data", 64'(od[0]), 64'hDEADBEEF);
        check("single.out_sel", 64'(os[0]), 64'd2);

        // round-robin fairness from a fresh reset
        cycle(1, 4'b0000, '0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 4'b1111, sq, 1);
            check("rr.fair_sel", 64'(os[0]), 64'(i % N));
            check("fx.prio_sel", 64'(os[1]), 64'd0);
        end

        // backpressure holds sel=1, then resumes at 2 with no bubble
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'b1111, sq, 0);
            check("bp.hold_sel", 64'(os[0]), 64'd1);
            check("bp.hold_ready", 64'(rdy[0]), 64'd0);
        end
        cycle(0, 4'b1111, sq, 1);
        check("bp.resume_sel", 64'(os[0]), 64'd2);
        check("bp.resume_valid", 64'(ov[0]), 64'd1);

        // fixed priority starves channel 3
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'b1010, sq, 1);
            check("fx.starve_sel", 64'(os[1]), 64'd1);
        end

        // reset while output is stalled
        cycle(0, 4'b1111, sq, 0);
        cycle(1, 4'b1111, sq, 0);
        check("rst_mid.out_valid", 64'(ov[0]), 64'd0);
        cycle(0, 4'b1111, sq, 1);
        check("rst_mid.first_sel", 64'(os[0]), 64'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  N'($urandom_range(0, 15)),
                  rnd_data(),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_mux_param.md
Name: arb_mux_param

Overview:
- Parametrised successor to the combinational N:1 bus mux: an N-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Used wherever several requesters share one consumer, e.g. instruction-fetch and load/store ports sharing the memory bus, or multiple write-back sources sharing a register-file port.
- Selects one requester per cycle, by round-robin or fixed priority, and registers the chosen data together with its channel index.

Parameters:
- N, 2, number of input channels (N >= 1)
- WIDTH, 32, data width per channel
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- SELW, (N > 1 ? $clog2(N) : 1), selector/index width (derived; do not override)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- in_valid  input  N  per-channel request valid
- in_data  input  N*WIDTH  channel k data in bits [k*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept; transfer on channel k when in_valid[k] && in_ready[k]
- out_valid  output  1  registered output valid
- out_data  output  WIDTH  registered selected data
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  downstream accept

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Synchronous reset sets out_valid=0, out_data=0, out_sel=0, last_grant=N-1, so channel 0 has first priority after reset.
  - in_ready is all-zero while reset is high.
- Load enable: load_en = !out_valid || out_ready (combinational).
- Grant (combinational from in_valid, last_grant and ARB_MODE):
  - ARB_MODE=0: search starts at (last_grant+1) mod N, ascending with wrap, and takes the first asserted in_valid.
  - ARB_MODE=1: lowest asserted index.
  - grant_vld = |in_valid.
- in_ready[k] = load_en && grant_vld && (grant == k). At most one bit is set. in_ready must not depend on in_data.
- On clock edge with load_en:
  - If grant_vld: out_data <= channel grant data, out_sel <= grant, out_valid <= 1, last_grant <= grant.
  - Otherwise out_valid <= 0. out_data, out_sel and last_grant hold.
- On clock edge without load_en (out_valid && !out_ready): all registers hold. Output is stable under backpressure (AXI-style: valid/data must not change until accepted).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer/cycle when out_ready is held high.
- Fairness (ARB_MODE=0): with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0 with no repeats within N cycles.
- Channel order: a channel that drops in_valid before being granted simply loses its place; no per-channel state is stored.
- Simultaneous events: output accepted and new grant in the same cycle give a back-to-back transfer with no bubble.
- Reset mid-transfer: a pending out_valid is dropped. The upstream sees in_ready=0 that cycle, so no data is lost silently from the source's view.
- N=1: the arbiter degenerates. out_sel is constant 0 and the block reduces to a single register slice.
- No combinational path from in_valid/in_data to out_valid/out_data. There is a combinational path out_ready -> in_ready; this is accepted and documented.

Decomposition:
- Shared package: ARB_RR=0 and ARB_FIXED=1 constants, plus a clog2-with-min-1 function for SELW.
- One sub-module: rr_arbiter (inputs: req[N], last_grant, mode; outputs: grant index, grant_vld). It is purely combinational and reusable by other shared-resource blocks.
- The datapath mux and output register stay in arb_mux_param.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Single request (N=4, WIDTH=32): in_valid=0100, ch2 data=0xDEADBEEF, out_ready=1 -> in_ready=0100 in that cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2.
- Round-robin fairness: in_valid=1111 held, channel k data=0x1000+k, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 and out_data 0x1000..0x1003 repeating, one per cycle.
- Backpressure: out_valid=1 with out_sel=1 and out_ready=0 for 3 cycles while in_valid=1111 -> out_data/out_sel unchanged, in_ready=0000. On out_ready=1, next out_sel=2 with no bubble.
- Fixed priority (ARB_MODE=1): in_valid=1010 held, out_ready=1 -> out_sel=1 every cycle; channel 3 starves.
- Reset mid-operation: reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, in_ready=0000. After release with in_valid=1111, first grant is channel 0.
